// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcode encodings and FSM state type shared by the sequential ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_MUL = 4'b0100;
    localparam logic [3:0] c_OP_DIV = 4'b0101;
    localparam logic [3:0] c_OP_MOV = 4'b0111;
    localparam logic [3:0] c_OP_SWP = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
// ============================================================================
// Module   : alu_muldiv_iter
// Brief    : Unsigned one-bit-per-cycle shift-add multiplier / restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_muldiv_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 div_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   acc,
    output logic                 last
);

    localparam int c_CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_cur;
    logic [2*WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   w_b;
    logic               r_div;
    logic               w_div;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;

    // The load cycle already performs the first iteration, so only WIDTH-1
    // further steps remain once the operands are captured.
    always_comb begin
        w_cur   = load ? {{WIDTH{1'b0}}, a} : r_acc;
        w_b     = load ? b : r_b;
        w_div   = load ? div_mode : r_div;
        w_sum   = {1'b0, w_cur[2*WIDTH-1:WIDTH]} + (w_cur[0] ? {1'b0, w_b} : '0);
        w_shift = w_cur[2*WIDTH-1:WIDTH-1];
        w_trial = w_shift - {1'b0, w_b};
        if (w_div) begin
            if (w_trial[WIDTH]) begin
                w_nxt = {w_shift[WIDTH-1:0], w_cur[WIDTH-2:0], 1'b0};
            end else begin
                w_nxt = {w_trial[WIDTH-1:0], w_cur[WIDTH-2:0], 1'b1};
            end
        end else begin
            w_nxt = {w_sum, w_cur[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_b   <= '0;
            r_div <= 1'b0;
            r_cnt <= '0;
        end else if (load) begin
            r_acc <= w_nxt;
            r_b   <= b;
            r_div <= div_mode;
            r_cnt <= c_CNT_W'(WIDTH - 1);
        end else if (step) begin
            r_acc <= w_nxt;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign acc  = r_acc;
    assign last = (r_cnt == c_CNT_W'(1));

endmodule : alu_muldiv_iter

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module   : alu_seq
// Brief    : Multi-cycle signed ALU: single-cycle add/sub/move/swap, iterative
//            mul/div behind a start/done handshake with status flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       functCode,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             o,
    output logic             z,
    output logic             n,
    output logic             dz,
    output logic             ill
);

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_div;

    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_o;
    logic               r_z;
    logic               r_n;
    logic               r_dz;
    logic               r_ill;

    logic               w_load;
    logic               w_step;
    logic               w_div_mode;
    logic               w_wr;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]   w_rem;
    logic               w_o;
    logic               w_dz;
    logic               w_ill;

    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_acc;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rmd;
    logic               w_last;

    // Magnitude of the most-negative value is representable as unsigned.
    assign w_mag1 = op1[WIDTH-1] ? (~op1 + 1'b1) : op1;
    assign w_mag2 = op2[WIDTH-1] ? (~op2 + 1'b1) : op2;
    assign w_sum  = op1 + op2;
    assign w_diff = op1 - op2;

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .step     (w_step),
        .div_mode (w_div_mode),
        .a        (w_mag1),
        .b        (w_mag2),
        .acc      (w_acc),
        .last     (w_last)
    );

    assign w_prod = r_neg_res ? (~w_acc + 1'b1) : w_acc;
    assign w_quo  = r_neg_res ? (~w_acc[WIDTH-1:0] + 1'b1) : w_acc[WIDTH-1:0];
    assign w_rmd  = r_neg_rem ? (~w_acc[2*WIDTH-1:WIDTH] + 1'b1) : w_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_div_mode  = 1'b0;
        w_wr        = 1'b0;
        w_res       = '0;
        w_rem       = '0;
        w_o         = 1'b0;
        w_dz        = 1'b0;
        w_ill       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (functCode)
                        c_OP_ADD: begin
                            w_wr  = 1'b1;
                            w_res = w_sum;
                            w_o   = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                                    (w_sum[WIDTH-1] != op1[WIDTH-1]);
                        end
                        c_OP_SUB: begin
                            w_wr  = 1'b1;
                            w_res = w_diff;
                            w_o   = (op1[WIDTH-1] != op2[WIDTH-1]) &&
                                    (w_diff[WIDTH-1] != op1[WIDTH-1]);
                        end
                        c_OP_MOV: begin
                            w_wr  = 1'b1;
                            w_res = op1;
                        end
                        c_OP_SWP: begin
                            w_wr  = 1'b1;
                            w_res = op1;
                            w_rem = op2;
                        end
                        c_OP_MUL: begin
                            w_load      = 1'b1;
                            w_state_nxt = S_MUL;
                        end
                        c_OP_DIV: begin
                            if (op2 == '0) begin
                                w_wr  = 1'b1;
                                w_dz  = 1'b1;
                                w_rem = op1;
                            end else begin
                                w_load      = 1'b1;
                                w_div_mode  = 1'b1;
                                w_state_nxt = S_DIV;
                            end
                        end
                        default: begin
                            w_wr  = 1'b1;
                            w_ill = 1'b1;
                        end
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_wr        = 1'b1;
                w_state_nxt = S_IDLE;
                if (r_div) begin
                    w_res = w_quo;
                    w_rem = w_rmd;
                    // Only most-negative / -1 yields a positive quotient of 2^(WIDTH-1).
                    w_o   = !r_neg_res && w_acc[WIDTH-1];
                end else begin
                    w_res = w_prod[WIDTH-1:0];
                    w_rem = w_prod[2*WIDTH-1:WIDTH];
                    w_o   = !((&w_prod[2*WIDTH-1:WIDTH-1]) || !(|w_prod[2*WIDTH-1:WIDTH-1]));
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div     <= 1'b0;
        end else if (w_load) begin
            r_neg_res <= op1[WIDTH-1] ^ op2[WIDTH-1];
            r_neg_rem <= op1[WIDTH-1];
            r_div     <= w_div_mode;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done      <= 1'b0;
            r_result    <= '0;
            r_remainder <= '0;
            r_o         <= 1'b0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_dz        <= 1'b0;
            r_ill       <= 1'b0;
        end else begin
            r_done <= w_wr;
            if (w_wr) begin
                r_result    <= w_res;
                r_remainder <= w_rem;
                r_o         <= w_o;
                r_z         <= (w_res == '0);
                r_n         <= w_res[WIDTH-1];
                r_dz        <= w_dz;
                r_ill       <= w_ill;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign result    = r_result;
    assign remainder = r_remainder;
    assign o         = r_o;
    assign z         = r_z;
    assign n         = r_n;
    assign dz        = r_dz;
    assign ill       = r_ill;

endmodule : alu_seq

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Directed self-checking bench for alu_seq at WIDTH=16.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  functCode;
    logic [15:0] op1;
    logic [15:0] op2;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [15:0] remainder;
    logic        o;
    logic        z;
    logic        n;
    logic        dz;
    logic        ill;

    int checks;
    int errors;

    alu_seq #(
        .WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .functCode (functCode),
        .op1       (op1),
        .op2       (op2),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .remainder (remainder),
        .o         (o),
        .z         (z),
        .n         (n),
        .dz        (dz),
        .ill       (ill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request for one cycle; returns #1 after the sampling edge.
    task automatic issue(input logic [3:0] fc, input logic [15:0] a, input logic [15:0] b);
        start     = 1'b1;
        functCode = fc;
        op1       = a;
        op2       = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Cycles from the request cycle to done; -1 if the bound expires.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = 1;
        busy_ok = 1'b1;
        while (!done && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset;
        checks++;
        if ({busy, done, o, z, n, dz, ill, result, remainder} !== 39'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {busy, done, o, z, n, dz, ill, result, remainder});
        end
    endtask

    task automatic test_add_sub;
        issue(4'b0000, 16'h7FFF, 16'h0001);
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++; $display("FAIL add_done: got %b expected 10", {done, busy});
        end
        checks++;
        if (result !== 16'h8000) begin
            errors++; $display("FAIL add_result: got %h expected 8000", result);
        end
        checks++;
        if ({o, n, z} !== 3'b110) begin
            errors++; $display("FAIL add_flags: got %b expected 110", {o, n, z});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({done, result, o} !== {1'b0, 16'h8000, 1'b1}) begin
            errors++; $display("FAIL add_hold: got %h expected %h", {done, result, o}, {1'b0, 16'h8000, 1'b1});
        end
        issue(4'b0001, 16'h8000, 16'h0001);
        checks++;
        if ({result, o, n, z} !== {16'h7FFF, 3'b100}) begin
            errors++; $display("FAIL sub_ovf: got %h expected %h", {result, o, n, z}, {16'h7FFF, 3'b100});
        end
        issue(4'b0000, 16'h0005, 16'hFFFB);
        checks++;
        if ({result, o, n, z} !== {16'h0000, 3'b001}) begin
            errors++; $display("FAIL add_zero: got %h expected %h", {result, o, n, z}, {16'h0000, 3'b001});
        end
        issue(4'b0111, 16'hFFFE, 16'h1234);
        checks++;
        if ({done, result, remainder, n} !== {1'b1, 16'hFFFE, 16'h0000, 1'b1}) begin
            errors++; $display("FAIL move: got %h expected %h", {done, result, remainder, n}, {1'b1, 16'hFFFE, 16'h0000, 1'b1});
        end
    endtask

    task automatic test_mul;
        int lat;
        bit bok;
        issue(4'b0100, 16'hFED4, 16'h00C8);
        wait_done(lat, bok);
        checks++;
        if (lat !== 17 || bok !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL mul_latency: got lat=%0d busy_ok=%0d busy=%0d expected 17 1 0", lat, bok, busy);
        end
        checks++;
        if ({result, remainder} !== {16'h15A0, 16'hFFFF}) begin
            errors++; $display("FAIL mul_result: got %h expected 15a0ffff", {result, remainder});
        end
        checks++;
        if ({o, n, z} !== 3'b100) begin
            errors++; $display("FAIL mul_flags: got %b expected 100", {o, n, z});
        end
        issue(4'b0100, 16'h0007, 16'hFFFD);
        wait_done(lat, bok);
        checks++;
        if ({result, remainder, o, n, z} !== {16'hFFEB, 16'hFFFF, 3'b010}) begin
            errors++; $display("FAIL mul_small: got %h expected %h", {result, remainder, o, n, z}, {16'hFFEB, 16'hFFFF, 3'b010});
        end
    endtask

    task automatic test_div;
        int lat;
        bit bok;
        issue(4'b0101, 16'h0064, 16'h0007);
        wait_done(lat, bok);
        checks++;
        if (lat !== 17 || bok !== 1'b1) begin
            errors++; $display("FAIL div_latency: got lat=%0d busy_ok=%0d expected 17 1", lat, bok);
        end
        checks++;
        if ({result, remainder, o} !== {16'h000E, 16'h0002, 1'b0}) begin
            errors++; $display("FAIL div_pos: got %h expected %h", {result, remainder, o}, {16'h000E, 16'h0002, 1'b0});
        end
        issue(4'b0101, 16'hFFF9, 16'h0002);
        wait_done(lat, bok);
        checks++;
        if ({result, remainder, o, n, z} !== {16'hFFFD, 16'hFFFF, 3'b010}) begin
            errors++; $display("FAIL div_neg: got %h expected %h", {result, remainder, o, n, z}, {16'hFFFD, 16'hFFFF, 3'b010});
        end
        issue(4'b0101, 16'h8000, 16'hFFFF);
        wait_done(lat, bok);
        checks++;
        if ({result, remainder, o, n} !== {16'h8000, 16'h0000, 2'b11}) begin
            errors++; $display("FAIL div_ovf: got %h expected %h", {result, remainder, o, n}, {16'h8000, 16'h0000, 2'b11});
        end
    endtask

    task automatic test_div_zero_illegal;
        issue(4'b0101, 16'h0005, 16'h0000);
        checks++;
        if ({done, busy, dz, o, z, ill} !== 6'b101010) begin
            errors++; $display("FAIL divzero_flags: got %b expected 101010", {done, busy, dz, o, z, ill});
        end
        checks++;
        if ({result, remainder} !== {16'h0000, 16'h0005}) begin
            errors++; $display("FAIL divzero_values: got %h expected 00000005", {result, remainder});
        end
        issue(4'b0010, 16'h0005, 16'h0006);
        checks++;
        if ({done, ill, dz, result, remainder} !== {3'b110, 32'h0}) begin
            errors++; $display("FAIL illegal: got %h expected %h", {done, ill, dz, result, remainder}, {3'b110, 32'h0});
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        issue(4'b1000, 16'h0003, 16'h0009);
        checks++;
        if ({done, result, remainder, ill} !== {1'b1, 16'h0003, 16'h0009, 1'b0}) begin
            errors++; $display("FAIL swap: got %h expected %h", {done, result, remainder, ill}, {1'b1, 16'h0003, 16'h0009, 1'b0});
        end
        issue(4'b0100, 16'h0002, 16'h0003);
        lat = 1;
        repeat (4) begin
            @(posedge clk);
            #1;
            lat++;
        end
        // Request during busy must be dropped.
        start = 1'b1; functCode = 4'b0000; op1 = 16'h0001; op2 = 16'h0001;
        @(posedge clk);
        #1;
        lat++;
        start = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 17 || result !== 16'h0006 || remainder !== 16'h0000) begin
            errors++; $display("FAIL ignored_start: got lat=%0d result=%h rem=%h expected 17 0006 0000", lat, result, remainder);
        end
        issue(4'b0000, 16'h000A, 16'h0014);
        checks++;
        if ({done, result} !== {1'b1, 16'h001E}) begin
            errors++; $display("FAIL back_to_back: got %h expected %h", {done, result}, {1'b1, 16'h001E});
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        bit bok;
        bit seen;
        issue(4'b0101, 16'h03E8, 16'h0003);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, o, z, n, dz, ill, result, remainder} !== 39'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h expected 0",
                     {busy, done, o, z, n, dz, ill, result, remainder});
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL midreset_abort: got done/busy activity 1 expected 0");
        end
        issue(4'b0101, 16'h0064, 16'h0007);
        wait_done(lat, bok);
        checks++;
        if (lat !== 17 || {result, remainder} !== {16'h000E, 16'h0002}) begin
            errors++; $display("FAIL post_reset_div: got lat=%0d %h expected 17 000e0002", lat, {result, remainder});
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        start     = 1'b0;
        functCode = 4'b0000;
        op1       = 16'h0000;
        op2       = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_add_sub;
        test_mul;
        test_div;
        test_div_zero_illegal;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alu_seq

`default_nettype wire
